// File: rtl/lzc_rr_norm_sched.sv
// Purpose: round-robin scheduler feeding one shared leading-zero normalizer; results tagged with requester index.
// Latency: 2 cycles from request handshake to rsp_valid_o (one arbitration/capture stage, one normalize stage).
// Backpressure: holds rsp_* while rsp_ready_i is low; absorbs 2 entries, then drops every req_ready_o.
//
// Ports:
//   clk_i, rst_ni                 clock (rising edge), async active-low reset
//   req_valid_i / req_ready_o     per-requester handshake, at most one ready bit set
//   req_mant_i                    packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid_o / rsp_ready_i     result handshake
//   rsp_id_o, rsp_mant_o          requester tag, normalized mantissa
//   rsp_shamt_o, rsp_zero_o       leading-zero count applied, operand-was-zero flag
//   busy_o                        any pipeline stage occupied
module lzc_rr_norm_sched #(
  parameter int NumReq = 4,
  parameter int WIDTH  = 32,
  localparam int IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1,
  localparam int CntW  = $clog2(WIDTH)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NumReq-1:0]       req_valid_i,
  output logic [NumReq-1:0]       req_ready_o,
  input  logic [NumReq*WIDTH-1:0] req_mant_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [IdxW-1:0]         rsp_id_o,
  output logic [WIDTH-1:0]        rsp_mant_o,
  output logic [CntW-1:0]         rsp_shamt_o,
  output logic                    rsp_zero_o,
  output logic                    busy_o
);

  // (a + b) mod NumReq for a < NumReq, b <= NumReq; one conditional subtract
  // gives the correct wrap even when NumReq is not a power of two.
  function automatic logic [IdxW-1:0] wrap_add(input logic [IdxW-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= NumReq) s = s - NumReq;
    return IdxW'(s);
  endfunction

  logic [IdxW-1:0]  r_ptr;
  logic             r_s1_vld;
  logic [IdxW-1:0]  r_s1_id;
  logic [WIDTH-1:0] r_s1_mant;
  logic             r_s2_vld;
  logic [IdxW-1:0]  r_s2_id;
  logic [WIDTH-1:0] r_s2_mant;
  logic [CntW-1:0]  r_s2_shamt;
  logic             r_s2_zero;

  logic [NumReq-1:0] w_rot;
  logic [IdxW-1:0]   w_cnt;
  logic [IdxW-1:0]   w_gnt;
  logic              w_any;
  logic              w_s2_free;
  logic              w_s1_acc;
  logic              w_hs;
  logic [WIDTH-1:0]  w_sel_mant;
  logic [CntW-1:0]   w_lzc;
  logic              w_nz;
  logic [WIDTH-1:0]  w_norm;

  // Arbitration: rotate so the pointer position lands at bit 0, then the
  // lowest set bit (trailing-zero count) is the distance to the winner.
  always_comb begin
    w_rot = '0;
    for (int i = 0; i < NumReq; i++) begin
      w_rot[i] = req_valid_i[wrap_add(r_ptr, i)];
    end
    w_cnt = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (w_rot[i]) w_cnt = IdxW'(i);
    end
    w_any = |req_valid_i;
    w_gnt = wrap_add(r_ptr, int'(w_cnt));
  end

  // Stage 2 frees up when empty or being consumed; stage 1 accepts when
  // empty or moving into stage 2 this cycle. Ready is held low in reset.
  assign w_s2_free = !r_s2_vld || rsp_ready_i;
  assign w_s1_acc  = !r_s1_vld || w_s2_free;
  assign w_hs      = w_any && w_s1_acc && rst_ni;

  always_comb begin
    req_ready_o = '0;
    if (w_hs) req_ready_o[w_gnt] = 1'b1;
    w_sel_mant = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (IdxW'(i) == w_gnt) w_sel_mant = req_mant_i[i*WIDTH +: WIDTH];
    end
  end

  // Leading-zero count: highest set bit wins (later iterations override).
  // A zero operand leaves the count at 0, which is the required shamt.
  always_comb begin
    w_lzc = '0;
    w_nz  = |r_s1_mant;
    for (int i = 0; i < WIDTH; i++) begin
      if (r_s1_mant[i]) w_lzc = CntW'(WIDTH - 1 - i);
    end
    w_norm = r_s1_mant << w_lzc;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr      <= '0;
      r_s1_vld   <= 1'b0;
      r_s1_id    <= '0;
      r_s1_mant  <= '0;
      r_s2_vld   <= 1'b0;
      r_s2_id    <= '0;
      r_s2_mant  <= '0;
      r_s2_shamt <= '0;
      r_s2_zero  <= 1'b0;
    end else begin
      if (w_hs) r_ptr <= wrap_add(w_gnt, 1);

      if (w_s1_acc) begin
        r_s1_vld <= w_hs;
        if (w_hs) begin
          r_s1_id   <= w_gnt;
          r_s1_mant <= w_sel_mant;
        end
      end

      // Payload only updates with a real entry so idle outputs stay quiet.
      if (w_s2_free) begin
        r_s2_vld <= r_s1_vld;
        if (r_s1_vld) begin
          r_s2_id    <= r_s1_id;
          r_s2_mant  <= w_nz ? w_norm : '0;
          r_s2_shamt <= w_nz ? w_lzc : '0;
          r_s2_zero  <= !w_nz;
        end
      end
    end
  end

  assign rsp_valid_o = r_s2_vld;
  assign rsp_id_o    = r_s2_id;
  assign rsp_mant_o  = r_s2_mant;
  assign rsp_shamt_o = r_s2_shamt;
  assign rsp_zero_o  = r_s2_zero;
  assign busy_o      = r_s1_vld || r_s2_vld;

endmodule

// File: tb/tb_lzc_rr_norm_sched.sv
// Bench for lzc_rr_norm_sched: 4-requester instance checked against a queue-based
// reference every cycle, plus a 3-requester instance for non-power-of-two wrap.
module tb_lzc_rr_norm_sched;
  localparam int N = 4;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [N-1:0]   vld;
  logic [N-1:0]   rdy;
  logic [W-1:0]   mant [N];
  logic [N*W-1:0] mant_bus;
  logic           rsp_vld, rsp_rdy, rsp_zero, busy;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_mant;
  logic [4:0]     rsp_shamt;

  logic [2:0]     vld3, rdy3;
  logic [W-1:0]   mant3 [3];
  logic [3*W-1:0] mant3_bus;
  logic           rsp_vld3, rsp_rdy3, rsp_zero3, busy3;
  logic [1:0]     rsp_id3;
  logic [W-1:0]   rsp_mant3;
  logic [4:0]     rsp_shamt3;

  for (genvar i = 0; i < N; i++) begin : g_pack4
    assign mant_bus[i*W +: W] = mant[i];
  end
  for (genvar i = 0; i < 3; i++) begin : g_pack3
    assign mant3_bus[i*W +: W] = mant3[i];
  end

  lzc_rr_norm_sched #(.NumReq(N), .WIDTH(W)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(vld), .req_ready_o(rdy), .req_mant_i(mant_bus),
    .rsp_valid_o(rsp_vld), .rsp_ready_i(rsp_rdy), .rsp_id_o(rsp_id),
    .rsp_mant_o(rsp_mant), .rsp_shamt_o(rsp_shamt), .rsp_zero_o(rsp_zero),
    .busy_o(busy)
  );

  lzc_rr_norm_sched #(.NumReq(3), .WIDTH(W)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(vld3), .req_ready_o(rdy3), .req_mant_i(mant3_bus),
    .rsp_valid_o(rsp_vld3), .rsp_ready_i(rsp_rdy3), .rsp_id_o(rsp_id3),
    .rsp_mant_o(rsp_mant3), .rsp_shamt_o(rsp_shamt3), .rsp_zero_o(rsp_zero3),
    .busy_o(busy3)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference normalization: shift left one place at a time until MSB is set.
  function automatic void ref_norm(input logic [W-1:0] m, output logic [W-1:0] nm,
                                   output int sh, output logic z);
    z  = (m == '0);
    nm = m;
    sh = 0;
    if (!z) begin
      while (nm[W-1] == 1'b0) begin
        nm = nm << 1;
        sh++;
      end
    end
  endfunction

  // Reference model: in-flight entries in grant order, each tagged with the
  // cycle it was accepted. The oldest entry is on the output from two cycles
  // after its acceptance until consumed; at most two entries in flight.
  typedef struct {
    int         id;
    logic [W-1:0] m;
    int         acc;
  } ent_t;
  ent_t q[$];
  int   ptr = 0;
  int   cyc = 0;
  int   last_g;
  int   hs_cnt = 0;

  task automatic step();
    bit           presented, can, any, hs;
    int           g, occ_s1, sh;
    logic [N-1:0] exp_rdy;
    logic [W-1:0] nm;
    logic         z;
    @(negedge clk);
    presented = (q.size() > 0) && (cyc >= q[0].acc + 2);
    occ_s1    = q.size() - (presented ? 1 : 0);
    can       = (occ_s1 == 0) || !presented || rsp_rdy;
    any       = (vld != '0);
    g = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (vld[(ptr + k) % N]) g = (ptr + k) % N;
    end
    hs      = any && can;
    exp_rdy = hs ? N'(1 << g) : '0;
    check("req_ready", rdy, exp_rdy);
    check("rsp_valid", rsp_vld, presented);
    check("busy", busy, q.size() > 0);
    if (presented) begin
      ref_norm(q[0].m, nm, sh, z);
      check("rsp_id", rsp_id, q[0].id);
      check("rsp_mant", rsp_mant, nm);
      check("rsp_shamt", rsp_shamt, sh);
      check("rsp_zero", rsp_zero, z);
    end
    last_g = hs ? g : -1;
    @(posedge clk);
    if (presented && rsp_rdy) void'(q.pop_front());
    if (hs) begin
      q.push_back('{id: g, m: mant[g], acc: cyc});
      ptr = (g + 1) % N;
      hs_cnt++;
    end
    cyc++;
    #1;
  endtask

  task automatic hard_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    ptr = 0;
  endtask

  int   fair_exp [10] = '{0, 1, 2, 3, 0, 1, 3, 1, 3, 1};
  logic [2:0] n3_rdy_exp [7] = '{3'b010, 3'b100, 3'b001, 3'b100, 3'b001, 3'b000, 3'b000};
  int   n3_id_exp [5] = '{1, 2, 0, 2, 0};
  int   n3_sh_exp [3] = '{31, 8, 0};
  int   hs_before;

  initial begin
    rst_n   = 1'b0;
    vld     = '0;
    rsp_rdy = 1'b1;
    vld3    = '0;
    rsp_rdy3 = 1'b1;
    for (int i = 0; i < N; i++) mant[i] = '0;
    mant3[0] = 32'h0000_0001;
    mant3[1] = 32'h00ff_0000;
    mant3[2] = 32'h0000_0000;

    // Reset held 3 cycles, then released with no requests.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", rsp_vld, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_mant", rsp_mant, 0);
    check("rst_rsp_shamt", rsp_shamt, 0);
    check("rst_rsp_zero", rsp_zero, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", rdy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Non-power-of-two instance: steer ptr to 2, then 0 and 2 contend.
    for (int c = 0; c < 7; c++) begin
      vld3 = (c == 0) ? 3'b010 : (c < 5) ? 3'b101 : 3'b000;
      @(negedge clk);
      check("n3_ready", rdy3, n3_rdy_exp[c]);
      if (c >= 2) begin
        check("n3_rsp_valid", rsp_vld3, 1);
        check("n3_rsp_id", rsp_id3, n3_id_exp[c-2]);
        check("n3_rsp_shamt", rsp_shamt3, n3_sh_exp[n3_id_exp[c-2]]);
        check("n3_rsp_zero", rsp_zero3, n3_id_exp[c-2] == 2);
      end else begin
        check("n3_rsp_valid_idle", rsp_vld3, 0);
      end
      @(posedge clk);
      #1;
    end
    check("n3_rsp_mant_last", rsp_mant3, 32'h8000_0000);
    check("n3_busy_end", busy3, 0);

    // Idle cycle after release.
    step();

    // Single normalize: req 2, operand 0x1000.
    vld = 4'b0100; mant[2] = 32'h0000_1000;
    step();
    vld = '0;
    step();
    check("norm_rsp_valid", rsp_vld, 1);
    check("norm_rsp_id", rsp_id, 2);
    check("norm_rsp_mant", rsp_mant, 32'h8000_0000);
    check("norm_rsp_shamt", rsp_shamt, 19);
    check("norm_rsp_zero", rsp_zero, 0);
    step();

    // Zero operand and already-normalized operand from req 0.
    vld = 4'b0001; mant[0] = 32'h0000_0000;
    step();
    mant[0] = 32'h8000_0001;
    step();
    vld = '0;
    check("zero_rsp_mant", rsp_mant, 0);
    check("zero_rsp_shamt", rsp_shamt, 0);
    check("zero_rsp_zero", rsp_zero, 1);
    step();
    check("msb_rsp_mant", rsp_mant, 32'h8000_0001);
    check("msb_rsp_shamt", rsp_shamt, 0);
    step();

    // Fairness: all four valid from ptr 0, then only 1 and 3 from ptr 2.
    hard_reset();
    for (int i = 0; i < 10; i++) begin
      vld = (i < 6) ? 4'hF : 4'hA;
      for (int k = 0; k < N; k++) mant[k] = $urandom;
      step();
      check("fair_grant", last_g, fair_exp[i]);
    end
    vld = '0;
    repeat (3) step();

    // Backpressure: req 0 always valid, sink stalled 6 cycles.
    rsp_rdy = 1'b0;
    vld = 4'b0001;
    hs_before = hs_cnt;
    for (int i = 0; i < 6; i++) begin
      mant[0] = $urandom >> $urandom_range(0, 31);
      step();
    end
    check("bp_handshakes", hs_cnt - hs_before, 2);
    rsp_rdy = 1'b1;
    step();
    check("bp_release_accept", last_g, 0);
    vld = '0;
    repeat (4) step();

    // Reset asserted mid-cycle with both stages full.
    rsp_rdy = 1'b0;
    vld = 4'hF;
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", rsp_vld, 0);
    check("midrst_busy", busy, 0);
    check("midrst_req_ready", rdy, 0);
    q.delete();
    ptr = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp_rdy = 1'b1;
    step();
    check("midrst_ptr_zero", last_g, 0);
    vld = '0;
    repeat (3) step();

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      vld = N'($urandom_range(0, 15));
      for (int k = 0; k < N; k++) begin
        mant[k] = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom >> $urandom_range(0, 31));
      end
      rsp_rdy = ($urandom_range(0, 3) != 0);
      step();
    end

    // Drain.
    vld = '0;
    rsp_rdy = 1'b1;
    repeat (4) step();
    @(negedge clk);
    check("drain_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lzc_rr_norm_sched.md
# lzc_rr_norm_sched

Shared normalization scheduler for the FPU. NumReq requesters present unnormalized mantissas over valid/ready handshakes. The block picks one per cycle by round-robin, using a trailing-zero `lzc` on the rotated request vector. The winner goes through a single leading-zero `lzc` plus left shifter in a 2-stage pipeline, and the result returns tagged with the requester index.

## Interface
- NumReq, 4: number of requesters, ≥2, power of two not required.
- WIDTH, 32: mantissa width, ≥2.
- IdxW, max(1,$clog2(NumReq)): derived, do not override.
- CntW, $clog2(WIDTH): derived, do not override.
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset; one clock; reset is asynchronous and active-low.
- req_valid_i  in  NumReq  per-requester valid.
- req_ready_o  out  NumReq  per-requester ready; at most one bit set.
- req_mant_i  in  NumReq×WIDTH  operand of each requester.
- rsp_valid_o  out  1  result valid.
- rsp_ready_i  in  1  result accepted.
- rsp_id_o  out  IdxW  index of the requester that issued the result.
- rsp_mant_o  out  WIDTH  normalized mantissa: MSB = 1 unless the operand was zero.
- rsp_shamt_o  out  CntW  left-shift amount applied, equal to the leading-zero count.
- rsp_zero_o  out  1  operand was all zero.
- busy_o  out  1  either pipeline stage holds a valid entry.

## Operation
- **Arbitration (combinational)**
  - Rotate req_valid_i right by ptr.
  - Trailing-zero count of the rotated vector gives cnt.
  - Granted index g = (ptr + cnt) mod NumReq, with correct modular wrap for non-power-of-two NumReq.
  - When no request is valid, no grant is made.
- **Acceptance**
  - req_ready_o[g] = 1 only when some req_valid_i is set and stage 1 can accept.
  - Stage 1 can accept when it is empty or is advancing this cycle.
  - All other ready bits are 0.
  - A handshake is req_valid_i[g] & req_ready_o[g].
- **Round-robin pointer**
  - On a handshake, ptr ← (g+1) mod NumReq.
  - Otherwise ptr holds.
  - Reset value of ptr is 0.
- **Stage 1 register** captures {valid, id = g, operand}.
  - Advances when stage 2 is empty or stage 2 is being consumed (rsp_ready_i).
  - Refilled in the same cycle it advances.
- **Stage 2 (output) register**
  - Leading-zero `lzc` and shifter operate on the stage-1 operand.
  - Registered: rsp_mant_o = operand << lzc, rsp_shamt_o = lzc count, rsp_zero_o = (operand == 0).
  - Zero operand: rsp_mant_o = 0, rsp_shamt_o = 0, rsp_zero_o = 1. The raw lzc count is not used here.
- **Output hold**
  - While rsp_valid_o & !rsp_ready_i, all rsp_* outputs stay stable.
  - Stage 1 holds as well.
- **Ordering**: results leave in grant order. No reordering and no drops.

## Timing
- **Reset values**
  - rsp_valid_o = 0, rsp_id_o = 0, rsp_mant_o = 0, rsp_shamt_o = 0, rsp_zero_o = 0, busy_o = 0.
  - Both stage valids = 0, ptr = 0.
  - req_ready_o is combinational and reads 0 while no valid is present. During reset it is forced to 0.
- **Reset mid-operation**: asserting rst_ni clears both stages and ptr immediately, asynchronously. In-flight entries are discarded.
- **Latency**: a handshake in cycle N gives rsp_valid_o in cycle N+2, provided rsp_ready_i is held high.
- **Throughput**: one handshake per cycle with rsp_ready_i = 1.
- **Backpressure**
  - With rsp_ready_i = 0, the pipeline absorbs at most 2 entries (stage 1 + stage 2).
  - After that, all req_ready_o = 0.
  - In the cycle rsp_ready_i rises with both stages full, stage 2 is consumed, stage 1 moves to stage 2, and a new request is accepted into stage 1.
- **Single requester**: a requester repeatedly valid alone is granted every cycle; ptr keeps advancing past it.
- A requester that drops valid without a handshake is not granted. Arbitration is recomputed every cycle (non-sticky grant).
- **No combinational paths** from rsp_ready_i to the rsp_* outputs. req_ready_o may depend combinationally on rsp_ready_i and req_valid_i.

## Test plan
- **Reset**: rst_ni low 3 cycles, then released with no requests -> rsp_valid_o = 0, req_ready_o = 0, busy_o = 0. Asserting rst_ni while both stages are full -> rsp_valid_o = 0 in the same cycle, and ptr = 0 afterward.
- **Single normalize** (WIDTH = 32): req 2 sends 0x0000_1000 at cycle N with rsp_ready_i = 1 -> at N+2: rsp_id_o = 2, rsp_mant_o = 0x8000_0000, rsp_shamt_o = 19, rsp_zero_o = 0.
- **Zero operand**: req 0 sends 0x0000_0000 -> rsp_mant_o = 0, rsp_shamt_o = 0, rsp_zero_o = 1. Operand 0x8000_0001 -> shamt 0, mant unchanged.
- **Fairness**: all 4 requesters valid continuously, rsp_ready_i = 1 -> grant order 0, 1, 2, 3, 0, 1…; one rsp per cycle, rsp_id_o in the same sequence. Then only req 1 and req 3 valid with ptr = 2 -> grants 3, 1, 3, 1.
- **Backpressure**: rsp_ready_i = 0 for 6 cycles with req 0 always valid -> exactly 2 handshakes, then req_ready_o = 0. rsp_* stay stable throughout. After release, results drain in order with nothing lost or duplicated.
- **Non-power-of-two** (NumReq = 3): requesters 0 and 2 valid, ptr = 2 -> grants 2, 0, 2. ptr wraps 2 -> 0 and never reaches 3.
